// File: rtl/arcino_prefetch_buffer_mo.sv
// ARCINO instruction prefetcher with pipelined memory requests and a registered
// instruction FIFO; branches flush the FIFO and discard in-flight responses.
module arcino_prefetch_buffer_mo #(
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_ADDR      = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_rvalid_i,
    output logic        busy_o
);

    localparam int FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int OPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]    next_addr;
    logic           req_pending;
    logic [OCW-1:0] outstanding_cnt;
    logic [OCW-1:0] discard_cnt;

    logic [31:0]    fifo_rdata [FIFO_DEPTH];
    logic [31:0]    fifo_addr  [FIFO_DEPTH];
    logic [FPW-1:0] fifo_wptr;
    logic [FPW-1:0] fifo_rptr;
    logic [FCW-1:0] fifo_count;

    // Granted addresses in request order, so each response can be tagged.
    logic [31:0]    oq_addr [MAX_OUTSTANDING];
    logic [OPW-1:0] oq_wptr;
    logic [OPW-1:0] oq_rptr;

    logic [31:0] branch_target;
    logic [31:0] live_level;
    logic        issue_ok;
    logic        grant;
    logic        rvalid_eff;
    logic        drop;
    logic        push;
    logic        pop;

    assign branch_target = addr_i & 32'hFFFF_FFFC;

    // Responses with nothing outstanding are stale (e.g. issued before a reset).
    assign rvalid_eff = instr_rvalid_i & (outstanding_cnt != '0);

    // Entries that will eventually occupy the FIFO: buffered plus live in-flight.
    assign live_level = 32'(fifo_count) + 32'(outstanding_cnt) - 32'(discard_cnt);
    assign issue_ok   = (32'(outstanding_cnt) < 32'(MAX_OUTSTANDING)) &&
                        (branch_i || (live_level < 32'(FIFO_DEPTH)));

    assign instr_req_o  = req_pending | (req_i & issue_ok);
    assign instr_addr_o = branch_i ? branch_target : next_addr;
    assign grant        = instr_req_o & instr_gnt_i;

    assign drop = rvalid_eff & (branch_i | (discard_cnt != '0));
    assign push = rvalid_eff & ~drop;

    assign valid_o = (fifo_count != '0);
    assign pop     = valid_o & ready_i & ~branch_i;
    assign rdata_o = valid_o ? fifo_rdata[fifo_rptr] : 32'h0;
    assign addr_o  = valid_o ? fifo_addr[fifo_rptr]  : 32'h0;
    assign busy_o  = (outstanding_cnt != '0) | instr_req_o;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            next_addr       <= RESET_ADDR;
            req_pending     <= 1'b0;
            outstanding_cnt <= '0;
            discard_cnt     <= '0;
            fifo_wptr       <= '0;
            fifo_rptr       <= '0;
            fifo_count      <= '0;
            oq_wptr         <= '0;
            oq_rptr         <= '0;
        end else begin
            req_pending <= instr_req_o & ~instr_gnt_i;

            if (branch_i) begin
                next_addr <= grant ? branch_target + 32'd4 : branch_target;
            end else if (grant) begin
                next_addr <= next_addr + 32'd4;
            end

            outstanding_cnt <= outstanding_cnt + OCW'(grant) - OCW'(rvalid_eff);

            if (branch_i) begin
                discard_cnt <= outstanding_cnt - OCW'(rvalid_eff);
            end else if (rvalid_eff && (discard_cnt != '0)) begin
                discard_cnt <= discard_cnt - OCW'(1);
            end

            if (grant) begin
                oq_wptr <= (oq_wptr == OPW'(MAX_OUTSTANDING - 1)) ? '0 : oq_wptr + OPW'(1);
            end
            if (rvalid_eff) begin
                oq_rptr <= (oq_rptr == OPW'(MAX_OUTSTANDING - 1)) ? '0 : oq_rptr + OPW'(1);
            end

            if (branch_i) begin
                fifo_wptr  <= '0;
                fifo_rptr  <= '0;
                fifo_count <= '0;
            end else begin
                if (push) begin
                    fifo_wptr <= (fifo_wptr == FPW'(FIFO_DEPTH - 1)) ? '0 : fifo_wptr + FPW'(1);
                end
                if (pop) begin
                    fifo_rptr <= (fifo_rptr == FPW'(FIFO_DEPTH - 1)) ? '0 : fifo_rptr + FPW'(1);
                end
                fifo_count <= fifo_count + FCW'(push) - FCW'(pop);
            end

            assert (!(push && !pop && (fifo_count == FCW'(FIFO_DEPTH))))
                else $error("prefetch FIFO overflow");
        end
    end

    // NOTE: storage arrays carry no reset; the pointers and counters alone
    // decide which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            oq_addr[oq_wptr] <= instr_addr_o;
        end
        if (push) begin
            fifo_rdata[fifo_wptr] <= instr_rdata_i;
            fifo_addr[fifo_wptr]  <= oq_addr[oq_rptr];
        end
    end

endmodule

// File: tb/tb_arcino_prefetch_buffer_mo.sv
// Directed bench for arcino_prefetch_buffer_mo: a memory model answers granted
// requests and a scoreboard queue holds the words the core should receive.
module tb_arcino_prefetch_buffer_mo;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic        ready_i = 1'b0;
    logic        valid_o;
    logic [31:0] rdata_o;
    logic [31:0] addr_o;
    logic        instr_req_o;
    logic        instr_gnt_i = 1'b0;
    logic [31:0] instr_addr_o;
    logic [31:0] instr_rdata_i = 32'h0;
    logic        instr_rvalid_i = 1'b0;
    logic        busy_o;

    arcino_prefetch_buffer_mo #(
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2),
        .RESET_ADDR      (32'h0000_0000)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .addr_i         (addr_i),
        .ready_i        (ready_i),
        .valid_o        (valid_o),
        .rdata_o        (rdata_o),
        .addr_o         (addr_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rdata_i  (instr_rdata_i),
        .instr_rvalid_i (instr_rvalid_i),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int chk_cnt  = 0;

    // Stimulus knobs read by cycle()
    bit          tb_req, tb_branch, tb_gnt, tb_ready, auto_resp, force_rv;
    logic [31:0] tb_baddr;

    // Reference model state
    logic [31:0] inflight [$];
    logic [31:0] exp_q    [$];
    int          disc;
    logic [31:0] model_next;
    int          grant_cnt;
    int          pop_cnt;
    logic        s_req;
    logic [31:0] s_addr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus: drive at negedge, check and update the model.
    task automatic cycle();
        logic [31:0] t, ra, a;
        bit rv, gr;
        @(negedge clk);
        rv = (auto_resp || force_rv) && (inflight.size() != 0);
        req_i          = tb_req;
        branch_i       = tb_branch;
        addr_i         = tb_baddr;
        ready_i        = tb_ready;
        instr_gnt_i    = tb_gnt;
        instr_rvalid_i = rv;
        instr_rdata_i  = rv ? mem_data(inflight[0]) : 32'h0;
        #1;
        t  = tb_baddr & 32'hFFFF_FFFC;
        ra = tb_branch ? t : model_next;
        s_req  = instr_req_o;
        s_addr = instr_addr_o;
        if (valid_o && tb_ready && !tb_branch) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                check("pop_with_empty_scoreboard", valid_o, 1'b0);
            end else begin
                a = exp_q.pop_front();
                check("pop_addr", addr_o, a);
                check("pop_data", rdata_o, mem_data(a));
            end
        end
        if (instr_req_o) check("req_addr", instr_addr_o, ra);
        gr = instr_req_o && tb_gnt;
        if (gr) grant_cnt++;
        if (rv) begin
            a = inflight.pop_front();
            if (!tb_branch) begin
                if (disc > 0) disc--;
                else exp_q.push_back(a);
            end
        end
        if (tb_branch) begin
            disc = inflight.size();
            exp_q.delete();
        end
        if (gr) inflight.push_back(ra);
        if (tb_branch) model_next = gr ? t + 32'd4 : t;
        else if (gr) model_next = model_next + 32'd4;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_ni = 1'b0;
        tb_req = 0; tb_branch = 0; tb_gnt = 0; tb_ready = 0;
        auto_resp = 0; force_rv = 0; tb_baddr = 32'h0;
        req_i = 0; branch_i = 0; addr_i = 32'h0; ready_i = 0;
        instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 32'h0;
        settle();
        check({tag, "_valid"}, valid_o, 1'b0);
        check({tag, "_req"},   instr_req_o, 1'b0);
        check({tag, "_busy"},  busy_o, 1'b0);
        check({tag, "_rdata"}, rdata_o, 32'h0);
        check({tag, "_addr"},  addr_o, 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        inflight.delete();
        exp_q.delete();
        disc = 0;
        model_next = 32'h0;
        grant_cnt = 0;
        pop_cnt = 0;
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 0;
        tb_req = 0; tb_branch = 0; tb_gnt = 1; tb_ready = 1; auto_resp = 1; force_rv = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            settle();
            if (exp_q.size() == 0 && inflight.size() == 0 && !valid_o) begin
                done = 1;
                break;
            end
        end
        check({tag, "_drained"}, {31'h0, done}, 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset("reset");

        // Streaming: gnt tied high, rvalid one cycle after gnt, core always ready
        tb_req = 1; tb_gnt = 1; tb_ready = 1; auto_resp = 1;
        cycle();
        settle();
        check("stream_valid_after_1", valid_o, 1'b0);
        cycle();
        settle();
        check("stream_valid_after_2", valid_o, 1'b1);
        pop_cnt = 0;
        repeat (8) cycle();
        check("stream_one_per_cycle", pop_cnt, 8);
        drain("stream");

        // Back-pressure: FIFO fills, requests stop; one pop frees one request
        do_reset("reset_bp");
        tb_req = 1; tb_gnt = 1; tb_ready = 0; auto_resp = 1;
        repeat (10) cycle();
        settle();
        check("bp_grant_count", grant_cnt, 4);
        check("bp_req_stopped", instr_req_o, 1'b0);
        tb_ready = 1;
        cycle();
        tb_ready = 0;
        repeat (5) cycle();
        settle();
        check("bp_one_more_grant", grant_cnt, 5);
        check("bp_req_stopped_again", instr_req_o, 1'b0);
        drain("bp");

        // Branch with two requests in flight: both responses discarded
        do_reset("reset_br");
        tb_req = 1; tb_gnt = 1; tb_ready = 1; auto_resp = 0; force_rv = 0;
        repeat (2) cycle();
        tb_branch = 1; tb_baddr = 32'h0000_0103;
        cycle();
        check("br_target_aligned", s_addr, 32'h0000_0100);
        tb_branch = 0; auto_resp = 1;
        pop_cnt = 0;
        repeat (6) cycle();
        check("br_one_word_delivered", pop_cnt > 0, 1'b1);
        drain("br");

        // Stalled grant: request and address hold; branch redirects the address
        do_reset("reset_stall");
        tb_req = 1; tb_gnt = 0; tb_ready = 1; auto_resp = 1;
        cycle();
        check("stall_req_c0", s_req, 1'b1);
        tb_req = 0;
        cycle();
        check("stall_req_held", s_req, 1'b1);
        check("stall_addr_held", s_addr, 32'h0);
        tb_branch = 1; tb_baddr = 32'h0000_0200;
        cycle();
        check("stall_branch_addr", s_addr, 32'h0000_0200);
        tb_branch = 0;
        cycle();
        check("stall_req_after_branch", s_req, 1'b1);
        check("stall_addr_after_branch", s_addr, 32'h0000_0200);
        tb_gnt = 1;
        cycle();
        check("stall_granted", grant_cnt, 1);
        drain("stall");

        // Branch coincident with the only outstanding response
        do_reset("reset_brv");
        tb_req = 1; tb_gnt = 1; tb_ready = 1; auto_resp = 0;
        cycle();
        tb_req = 0; force_rv = 1; tb_branch = 1; tb_baddr = 32'h0000_0300;
        cycle();
        settle();
        check("brv_valid_cleared", valid_o, 1'b0);
        check("brv_busy_idle", busy_o, 1'b0);
        tb_branch = 0; force_rv = 0; tb_req = 1; auto_resp = 1;
        pop_cnt = 0;
        repeat (4) cycle();
        check("brv_next_delivered", pop_cnt > 0, 1'b1);
        drain("brv");

        // Address wrap, then reset in the middle of traffic
        do_reset("reset_wrap");
        tb_req = 1; tb_gnt = 1; tb_ready = 1; auto_resp = 1;
        tb_branch = 1; tb_baddr = 32'hFFFF_FFFC;
        cycle();
        tb_branch = 0;
        cycle();
        check("wrap_next_addr", s_addr, 32'h0000_0000);
        repeat (2) cycle();
        do_reset("reset_midflight");

        // A stale response after reset is ignored
        @(negedge clk);
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = 32'hDEAD_BEEF;
        settle();
        check("stale_rvalid_busy", busy_o, 1'b0);
        check("stale_rvalid_valid", valid_o, 1'b0);
        @(negedge clk);
        instr_rvalid_i = 1'b0;
        settle();
        check("stale_rvalid_valid_later", valid_o, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
